// File: rtl/traffic_scheduler.sv
// Central scheduler for NUM_GEN traffic generators: forwards Init/Fill config in IDLE,
// round-robin issues credit-gated Dequeue ops in RUN, and reports completion/stall/errors.
// Latency: one cycle from handshake or grant to the op on gen_op_o; cfg_ready_o low outside IDLE.
module traffic_scheduler #(
    parameter int NUM_GEN = 4,
    parameter int GEN_IDW = 2,
    parameter int DATA_W  = 32,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [GEN_IDW-1:0]     cfg_gen_i,
    input  logic [2:0]             cfg_op_i,
    input  logic [DATA_W-1:0]      cfg_data_i,
    input  logic                   start_i,
    output logic [3*NUM_GEN-1:0]   gen_op_o,
    output logic [DATA_W-1:0]      gen_data_o,
    input  logic [NUM_GEN-1:0]     gen_done_i,
    input  logic [NUM_GEN-1:0]     credit_return_i,
    output logic                   busy_o,
    output logic                   run_done_o,
    output logic                   stall_o,
    output logic                   credit_err_o,
    output logic                   cfg_err_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [2:0] OP_INIT = 3'd5;
    localparam logic [2:0] OP_FILL = 3'd6;
    localparam logic [2:0] OP_DEQ  = 3'd7;
    localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CREDITS);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [GEN_IDW-1:0] IDX_LAST = GEN_IDW'(NUM_GEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3*NUM_GEN-1:0]   gen_op_q, gen_op_d;
    logic [DATA_W-1:0]      gen_data_q, gen_data_d;
    logic [GEN_IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CRED_W-1:0]      credit_q [NUM_GEN];
    logic [CRED_W-1:0]      credit_d [NUM_GEN];
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [1:0]             settle_q, settle_d;
    logic                   busy_q, busy_d;
    logic                   run_done_q, run_done_d;
    logic                   stall_q, stall_d;
    logic                   credit_err_q, credit_err_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [NUM_GEN-1:0]     eligible;
    logic [NUM_GEN-1:0]     grant_oh;
    logic                   grant_vld;
    logic [GEN_IDW-1:0]     grant_idx;
    logic                   all_done;
    logic                   cfg_legal;
    logic                   reload;

    assign all_done    = &gen_done_i;
    assign cfg_ready_o = (state_q == S_IDLE);
    assign cfg_legal   = ((cfg_op_i == OP_INIT) || (cfg_op_i == OP_FILL)) &&
                         (int'(cfg_gen_i) < NUM_GEN);

    // Round-robin pick: first eligible generator at or after rr_ptr, only while running.
    always_comb begin
        int scan;
        scan      = 0;
        eligible  = '0;
        grant_oh  = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_GEN; i++) begin
            eligible[i] = ~gen_done_i[i] & (credit_q[i] != '0);
        end
        for (int k = 0; k < NUM_GEN; k++) begin
            scan = int'(rr_ptr_q) + k;
            if (scan >= NUM_GEN) begin
                scan = scan - NUM_GEN;
            end
            if (!grant_vld && eligible[scan]) begin
                grant_vld = 1'b1;
                grant_idx = GEN_IDW'(scan);
            end
        end
        if (state_q != S_RUN) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Next-state, op issue, timeout/settle tracking and credit accounting.
    always_comb begin
        state_d      = state_q;
        gen_op_d     = '0;
        gen_data_d   = gen_data_q;
        rr_ptr_d     = rr_ptr_q;
        tmo_d        = tmo_q;
        settle_d     = settle_q;
        stall_d      = stall_q;
        credit_err_d = credit_err_q;
        cfg_err_d    = cfg_err_q;
        credit_d     = credit_q;
        reload       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid_i) begin
                    // A config handshake takes priority; a coincident start is dropped.
                    if (cfg_legal) begin
                        gen_op_d[3*cfg_gen_i +: 3] = cfg_op_i;
                        gen_data_d                 = cfg_data_i;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end else if (start_i) begin
                    state_d  = S_RUN;
                    tmo_d    = '0;
                    settle_d = '0;
                    reload   = 1'b1;
                end
            end
            S_RUN: begin
                if (grant_vld) begin
                    gen_op_d[3*grant_idx +: 3] = OP_DEQ;
                    rr_ptr_d = (grant_idx == IDX_LAST) ? '0 : grant_idx + GEN_IDW'(1);
                    tmo_d    = '0;
                end else if (!all_done) begin
                    if (tmo_q == TMO_LAST) begin
                        stall_d = 1'b1;
                        state_d = S_IDLE;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
                // Two quiet all-done cycles give the generators time to settle their done flags.
                if (all_done && !grant_vld) begin
                    settle_d = (settle_q == 2'd2) ? 2'd2 : settle_q + 2'd1;
                end else begin
                    settle_d = '0;
                end
                if (settle_q == 2'd2) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_GEN; i++) begin
            if (credit_return_i[i] && !grant_oh[i]) begin
                if (credit_q[i] == CRED_FULL) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + CRED_W'(1);
                end
            end else if (grant_oh[i] && !credit_return_i[i]) begin
                credit_d[i] = credit_q[i] - CRED_W'(1);
            end
            if (reload) begin
                credit_d[i] = CRED_FULL;
            end
        end

        busy_d     = (state_d != S_IDLE);
        run_done_d = (state_d == S_FINISH);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gen_op_q     <= '0;
            gen_data_q   <= '0;
            rr_ptr_q     <= '0;
            tmo_q        <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            run_done_q   <= 1'b0;
            stall_q      <= 1'b0;
            credit_err_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            for (int i = 0; i < NUM_GEN; i++) begin
                credit_q[i] <= CRED_FULL;
            end
        end else begin
            state_q      <= state_d;
            gen_op_q     <= gen_op_d;
            gen_data_q   <= gen_data_d;
            rr_ptr_q     <= rr_ptr_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
            busy_q       <= busy_d;
            run_done_q   <= run_done_d;
            stall_q      <= stall_d;
            credit_err_q <= credit_err_d;
            cfg_err_q    <= cfg_err_d;
            for (int i = 0; i < NUM_GEN; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign gen_op_o     = gen_op_q;
    assign gen_data_o   = gen_data_q;
    assign busy_o       = busy_q;
    assign run_done_o   = run_done_q;
    assign stall_o      = stall_q;
    assign credit_err_o = credit_err_q;
    assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Testbench for traffic_scheduler: directed phases plus a randomized run against a reference model.
// The model predicts issued ops from round-robin and credit rules; outputs sampled 1 time unit after each edge.
// Inputs driven with blocking assignments right after sampling.
module tb_traffic_scheduler;

    localparam int NG  = 4;
    localparam int GW  = 2;
    localparam int DW  = 32;
    localparam int CR  = 4;
    localparam int CW  = 3;
    localparam int TMO = 255;

    logic              clk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [GW-1:0]     cfg_gen;
    logic [2:0]        cfg_op;
    logic [DW-1:0]     cfg_data;
    logic              start;
    logic [3*NG-1:0]   gen_op;
    logic [DW-1:0]     gen_data;
    logic [NG-1:0]     gen_done;
    logic [NG-1:0]     credit_return;
    logic              busy;
    logic              run_done;
    logic              stall;
    logic              credit_err;
    logic              cfg_err;

    int errors;
    int checks;

    // Reference model state
    int              mcred [NG];
    int              mptr;
    bit              mrun;
    bit              merr;
    logic [3*NG-1:0] mexp_op;

    traffic_scheduler #(
        .NUM_GEN(NG), .GEN_IDW(GW), .DATA_W(DW),
        .CREDITS(CR), .CRED_W(CW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_gen_i(cfg_gen),
        .cfg_op_i(cfg_op),
        .cfg_data_i(cfg_data),
        .start_i(start),
        .gen_op_o(gen_op),
        .gen_data_o(gen_data),
        .gen_done_i(gen_done),
        .credit_return_i(credit_return),
        .busy_o(busy),
        .run_done_o(run_done),
        .stall_o(stall),
        .credit_err_o(credit_err),
        .cfg_err_o(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_idx(input logic [3*NG-1:0] v);
        for (int i = 0; i < NG; i++) begin
            if (v[3*i +: 3] != 3'd0) return i;
        end
        return -1;
    endfunction

    // Model one clock: pick the first ready generator from the pointer, then account credits.
    task automatic model_cycle();
        int g;
        g = -1;
        mexp_op = '0;
        if (mrun) begin
            for (int k = 0; k < NG; k++) begin
                int idx;
                idx = (mptr + k) % NG;
                if (g < 0 && !gen_done[idx] && mcred[idx] > 0) g = idx;
            end
        end
        if (g >= 0) begin
            mexp_op[3*g +: 3] = 3'd7;
            mptr = (g + 1) % NG;
        end
        for (int i = 0; i < NG; i++) begin
            if (credit_return[i] && i != g) begin
                if (mcred[i] == CR) merr = 1'b1;
                else mcred[i]++;
            end else if (!credit_return[i] && i == g) begin
                mcred[i]--;
            end
        end
    endtask

    task automatic step(input string tag);
        model_cycle();
        tick();
        check({tag, ":op"}, 64'(gen_op), 64'(mexp_op));
        check({tag, ":cerr"}, 64'(credit_err), 64'(merr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_valid = 1'b0;
        start = 1'b0;
        credit_return = '0;
        gen_done = '0;
        tick();
        tick();
        mptr = 0;
        mrun = 1'b0;
        merr = 1'b0;
        for (int i = 0; i < NG; i++) mcred[i] = CR;
        check("rst:op", 64'(gen_op), 64'd0);
        check("rst:data", 64'(gen_data), 64'd0);
        check("rst:busy", 64'(busy), 64'd0);
        check("rst:run_done", 64'(run_done), 64'd0);
        check("rst:stall", 64'(stall), 64'd0);
        check("rst:cerr", 64'(credit_err), 64'd0);
        check("rst:cfg_err", 64'(cfg_err), 64'd0);
        check("rst:ready", 64'(cfg_ready), 64'd1);
        rst = 1'b0;
    endtask

    task automatic do_start();
        cfg_valid = 1'b0;
        credit_return = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        mrun = 1'b1;
        for (int i = 0; i < NG; i++) mcred[i] = CR;
        check("start:busy", 64'(busy), 64'd1);
        check("start:ready", 64'(cfg_ready), 64'd0);
        check("start:op", 64'(gen_op), 64'd0);
    endtask

    task automatic do_cfg(input int g, input int op, input logic [DW-1:0] d);
        logic [3*NG-1:0] ev;
        ev = '0;
        ev[3*g +: 3] = 3'(op);
        cfg_valid = 1'b1;
        cfg_gen = GW'(g);
        cfg_op = 3'(op);
        cfg_data = d;
        tick();
        cfg_valid = 1'b0;
        check("cfg:op", 64'(gen_op), 64'(ev));
        check("cfg:data", 64'(gen_data), 64'(d));
    endtask

    initial begin
        logic [DW-1:0] rd;
        int seq[$];
        int exp_rr[12];
        int cnt;
        int k;
        bit saw_done;

        errors = 0;
        checks = 0;
        cfg_gen = '0;
        cfg_op = '0;
        cfg_data = '0;
        exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3, 0};

        // Reset state
        do_reset();

        // Config forwarding
        do_cfg(2, 5, 32'h00C0_0000);
        rd = $urandom;
        do_cfg(2, 6, rd);
        step("cfg_idle");
        for (int i = 0; i < 6; i++) begin
            do_cfg(int'($urandom_range(0, NG - 1)), int'($urandom_range(5, 6)), $urandom);
        end
        rd = gen_data;

        // Illegal op with a coincident start: nothing issued, start ignored, cfg_err sticky
        cfg_valid = 1'b1;
        cfg_gen = 2'd1;
        cfg_op = 3'd7;
        cfg_data = 32'hDEAD_BEEF;
        start = 1'b1;
        step("illegal");
        cfg_valid = 1'b0;
        start = 1'b0;
        check("illegal:cfg_err", 64'(cfg_err), 64'd1);
        check("illegal:busy", 64'(busy), 64'd0);
        check("illegal:data_held", 64'(gen_data), 64'(rd));
        for (int i = 0; i < 3; i++) step("illegal_after");
        check("illegal:sticky", 64'(cfg_err), 64'd1);

        // Round-robin with credits returned one cycle after each issue
        do_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 8) gen_done = 4'b0010;
            for (int j = 0; j < NG; j++) credit_return[j] = (gen_op[3*j +: 3] == 3'd7);
            step("rr");
            seq.push_back(op_idx(gen_op));
        end
        for (int i = 0; i < 12; i++) check("rr:order", 64'(seq[i]), 64'(exp_rr[i]));

        // Completion: run_done three cycles after all generators report done
        gen_done = '1;
        for (int j = 0; j < NG; j++) credit_return[j] = (gen_op[3*j +: 3] == 3'd7);
        step("cmp1");
        credit_return = '0;
        check("cmp1:run_done", 64'(run_done), 64'd0);
        check("cmp1:busy", 64'(busy), 64'd1);
        step("cmp2");
        check("cmp2:run_done", 64'(run_done), 64'd0);
        step("cmp3");
        mrun = 1'b0;
        check("cmp3:run_done", 64'(run_done), 64'd1);
        check("cmp3:busy", 64'(busy), 64'd1);
        step("cmp4");
        check("cmp4:run_done", 64'(run_done), 64'd0);
        check("cmp4:busy", 64'(busy), 64'd0);
        check("cmp4:ready", 64'(cfg_ready), 64'd1);

        // Credit limit: only gen0 active, no returns until one is given back
        gen_done = 4'b1110;
        do_start();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step("cred");
            if (gen_op[2:0] == 3'd7) cnt++;
        end
        check("cred:four_deq", 64'(cnt), 64'(CR));
        credit_return = 4'b0001;
        step("cred_ret");
        credit_return = '0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step("cred_more");
            if (gen_op[2:0] == 3'd7) cnt++;
        end
        check("cred:one_more", 64'(cnt), 64'd1);
        gen_done = '1;
        for (int i = 0; i < 4; i++) step("cred_end");
        mrun = 1'b0;
        credit_return = 4'b1000;
        step("cred_full");
        credit_return = '0;
        check("cred:err", 64'(credit_err), 64'd1);

        // Randomized run against the model
        do_reset();
        do_start();
        for (int i = 0; i < 150; i++) begin
            logic [NG-1:0] d;
            for (int j = 0; j < NG; j++) begin
                d[j] = ($urandom_range(0, 3) == 0);
                credit_return[j] = ($urandom_range(0, 9) < 3);
            end
            if (&d) d[$urandom_range(0, NG - 1)] = 1'b0;
            gen_done = d;
            step("rand");
        end
        credit_return = '0;
        gen_done = '1;
        for (int i = 0; i < 4; i++) step("rand_end");
        mrun = 1'b0;
        check("rand:idle", 64'(busy), 64'd0);

        // Stall: credits exhausted, nobody done, no returns
        do_reset();
        do_start();
        k = 0;
        saw_done = 1'b0;
        while (k < 400 && !stall) begin
            tick();
            k++;
            if (run_done) saw_done = 1'b1;
        end
        check("stall:cycles", 64'(k), 64'(NG * CR + TMO));
        check("stall:flag", 64'(stall), 64'd1);
        check("stall:no_run_done", 64'(saw_done), 64'd0);
        check("stall:busy", 64'(busy), 64'd0);
        check("stall:ready", 64'(cfg_ready), 64'd1);
        tick();
        check("stall:sticky", 64'(stall), 64'd1);

        // Reset in the middle of a run
        do_reset();
        do_cfg(1, 5, 32'h1234_5678);
        cfg_valid = 1'b1;
        cfg_op = 3'd0;
        step("pre_rst_bad");
        cfg_valid = 1'b0;
        do_start();
        for (int i = 0; i < 5; i++) step("pre_rst_run");
        rst = 1'b1;
        tick();
        check("midrst:op", 64'(gen_op), 64'd0);
        check("midrst:data", 64'(gen_data), 64'd0);
        check("midrst:busy", 64'(busy), 64'd0);
        check("midrst:cfg_err", 64'(cfg_err), 64'd0);
        check("midrst:ready", 64'(cfg_ready), 64'd1);
        tick();
        rst = 1'b0;
        mrun = 1'b0;
        mptr = 0;
        merr = 1'b0;
        for (int i = 0; i < NG; i++) mcred[i] = CR;
        for (int i = 0; i < 3; i++) step("post_rst");
        check("post_rst:busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
